// File: rtl/mcu_db_responder_if.sv
// Debug command bus between mcu_controller/CPU side (master) and mcu_db_responder (slave).
interface mcu_db_responder_if;
  logic        valid;
  logic        pause;
  logic        resume;
  logic        reset;
  logic        reg_rd;
  logic        reg_wr;
  logic        mem_rd;
  logic        mem_wr;
  logic        mem_rw_byte;
  logic [31:0] addr;
  logic [31:0] d_in;
  logic        mcu_busy;
  logic [31:0] d_rd;
  logic        error;
  logic        cpu_pause;
  logic        cpu_halted;
  logic        cpu_reset;
  logic [31:0] pc;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wd;
  logic        rf_we;
  logic [31:0] rf_rd;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  valid, pause, resume, reset, reg_rd, reg_wr, mem_rd, mem_wr,
           mem_rw_byte, addr, d_in, cpu_halted, pc, rf_rd, mem_rdata, mem_ack,
    output mcu_busy, d_rd, error, cpu_pause, cpu_reset, rf_addr, rf_wd, rf_we,
           mem_addr, mem_wdata, mem_be, mem_re, mem_we
  );

  modport master (
    output valid, pause, resume, reset, reg_rd, reg_wr, mem_rd, mem_wr,
           mem_rw_byte, addr, d_in, cpu_halted, pc, rf_rd, mem_rdata, mem_ack,
    input  mcu_busy, d_rd, error, cpu_pause, cpu_reset, rf_addr, rf_wd, rf_we,
           mem_addr, mem_wdata, mem_be, mem_re, mem_we
  );
endinterface

// File: rtl/mcu_db_responder.sv
// MCU-side debug command executor: CPU pause/resume/reset, register-file and data-memory access.
//
// state      | meaning
// IDLE       | waiting for a valid command strobe
// PAUSE_WAIT | cpu_pause asserted, waiting for cpu_halted
// RST        | cpu_reset pulse in progress
// REG        | one-cycle execute slot (register access, resume, rejected command)
// MEM        | memory request held until mem_ack or timeout
// DONE       | result published, one cycle before returning to IDLE
module mcu_db_responder #(
  parameter int MEM_TIMEOUT  = 255,
  parameter int RESET_CYCLES = 4
) (
  input logic               clk,
  input logic               rst_n,
  mcu_db_responder_if.slave bus
);
  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_PAUSE_WAIT = 3'd1;
  localparam logic [2:0] S_RST        = 3'd2;
  localparam logic [2:0] S_REG        = 3'd3;
  localparam logic [2:0] S_MEM        = 3'd4;
  localparam logic [2:0] S_DONE       = 3'd5;

  localparam int CMAX = (MEM_TIMEOUT > RESET_CYCLES) ? MEM_TIMEOUT : RESET_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_paused;
  logic          r_cpu_reset;
  logic          r_is_rd;
  logic          r_err;
  logic          r_byte;
  logic [1:0]    r_lane;
  logic [31:0]   r_d_rd;
  logic          r_error;
  logic [4:0]    r_rf_addr;
  logic [31:0]   r_rf_wd;
  logic          r_rf_we;
  logic [31:0]   r_mem_addr;
  logic [31:0]   r_mem_wdata;
  logic [3:0]    r_mem_be;
  logic          r_mem_re;
  logic          r_mem_we;

  logic [6:0]    w_sel;
  logic          w_reg;
  logic          w_mem;
  logic          w_bad;
  logic [31:0]   w_rd_data;
  logic          w_unused;

  assign w_sel = {bus.pause, bus.resume, bus.reset, bus.reg_rd, bus.reg_wr, bus.mem_rd, bus.mem_wr};
  assign w_reg = bus.reg_rd | bus.reg_wr;
  assign w_mem = bus.mem_rd | bus.mem_wr;
  assign w_bad = !$onehot(w_sel)
               | (w_reg & (!r_paused | (|bus.addr[31:5])))
               | (w_mem & (!r_paused | (!bus.mem_rw_byte & (|bus.addr[1:0]))));

  assign w_rd_data = r_byte ? {24'd0, bus.mem_rdata[{r_lane, 3'b000} +: 8]} : bus.mem_rdata;
  assign w_unused  = ^bus.pc;

  // Resume and rejected commands pass through REG so every short command has the same latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_paused    <= 1'b0;
      r_cpu_reset <= 1'b0;
      r_is_rd     <= 1'b0;
      r_err       <= 1'b0;
      r_byte      <= 1'b0;
      r_lane      <= 2'd0;
      r_d_rd      <= 32'd0;
      r_error     <= 1'b0;
      r_rf_addr   <= 5'd0;
      r_rf_wd     <= 32'd0;
      r_rf_we     <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_mem_be    <= 4'd0;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
    end else begin
      r_rf_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.valid) begin
            r_is_rd <= bus.reg_rd | bus.mem_rd;
            r_err   <= w_bad;
            if (w_bad) begin
              r_state <= S_REG;
            end else if (bus.pause) begin
              r_paused <= 1'b1;
              r_state  <= S_PAUSE_WAIT;
            end else if (bus.resume) begin
              r_paused <= 1'b0;
              r_state  <= S_REG;
            end else if (bus.reset) begin
              r_cpu_reset <= 1'b1;
              r_cnt       <= CW'(RESET_CYCLES);
              r_state     <= S_RST;
            end else if (w_reg) begin
              r_rf_addr <= bus.addr[4:0];
              r_rf_wd   <= bus.d_in;
              r_rf_we   <= bus.reg_wr;
              r_state   <= S_REG;
            end else begin
              r_mem_addr  <= {bus.addr[31:2], 2'b00};
              r_mem_be    <= bus.mem_rw_byte ? 4'(4'b0001 << bus.addr[1:0]) : 4'hF;
              r_mem_wdata <= bus.mem_rw_byte ? {4{bus.d_in[7:0]}} : bus.d_in;
              r_mem_re    <= bus.mem_rd;
              r_mem_we    <= bus.mem_wr;
              r_lane      <= bus.addr[1:0];
              r_byte      <= bus.mem_rw_byte;
              r_cnt       <= CW'(MEM_TIMEOUT - 1);
              r_state     <= S_MEM;
            end
          end
        end
        S_PAUSE_WAIT: begin
          if (bus.cpu_halted) begin
            r_error <= 1'b0;
            r_state <= S_DONE;
          end
        end
        S_RST: begin
          if (r_cnt == CW'(1)) r_cpu_reset <= 1'b0;
          if (r_cnt == '0) begin
            r_error <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_REG: begin
          r_error <= r_err;
          if (!r_err && r_is_rd) r_d_rd <= bus.rf_rd;
          r_state <= S_DONE;
        end
        S_MEM: begin
          if (bus.mem_ack) begin
            r_mem_re <= 1'b0;
            r_mem_we <= 1'b0;
            r_error  <= 1'b0;
            if (r_is_rd) r_d_rd <= w_rd_data;
            r_state  <= S_DONE;
          end else if (r_cnt == '0) begin
            r_mem_re <= 1'b0;
            r_mem_we <= 1'b0;
            r_error  <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mcu_busy  = (r_state != S_IDLE);
  assign bus.d_rd      = r_d_rd;
  assign bus.error     = r_error;
  assign bus.cpu_pause = r_paused;
  assign bus.cpu_reset = r_cpu_reset;
  assign bus.rf_addr   = r_rf_addr;
  assign bus.rf_wd     = r_rf_wd;
  assign bus.rf_we     = r_rf_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_be    = r_mem_be;
  assign bus.mem_re    = r_mem_re;
  assign bus.mem_we    = r_mem_we;
endmodule

// File: tb/tb_mcu_db_responder.sv
// Directed bench for mcu_db_responder with a small register-file model and bench-driven memory ack.
module tb_mcu_db_responder;
  localparam logic [6:0] C_PAUSE  = 7'b1000000;
  localparam logic [6:0] C_RESUME = 7'b0100000;
  localparam logic [6:0] C_RESET  = 7'b0010000;
  localparam logic [6:0] C_REG_RD = 7'b0001000;
  localparam logic [6:0] C_REG_WR = 7'b0000100;
  localparam logic [6:0] C_MEM_RD = 7'b0000010;
  localparam logic [6:0] C_MEM_WR = 7'b0000001;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;
  logic [31:0] rf_mem [32];

  mcu_db_responder_if bus_if();

  mcu_db_responder #(.MEM_TIMEOUT(8), .RESET_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus_if.rf_rd = (bus_if.rf_addr == 5'd0) ? 32'd0 : rf_mem[bus_if.rf_addr];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= 32'd0;
    end else if (bus_if.rf_we && bus_if.rf_addr != 5'd0) begin
      rf_mem[bus_if.rf_addr] <= bus_if.rf_wd;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives a one-cycle strobe; returns in cycle N+1.
  task automatic send(input logic [6:0] sel, input logic byte_acc, input logic [31:0] a, input logic [31:0] d);
    bus_if.valid = 1'b1;
    {bus_if.pause, bus_if.resume, bus_if.reset, bus_if.reg_rd,
     bus_if.reg_wr, bus_if.mem_rd, bus_if.mem_wr} = sel;
    bus_if.mem_rw_byte = byte_acc;
    bus_if.addr = a;
    bus_if.d_in = d;
    tick();
    bus_if.valid = 1'b0;
    {bus_if.pause, bus_if.resume, bus_if.reset, bus_if.reg_rd,
     bus_if.reg_wr, bus_if.mem_rd, bus_if.mem_wr} = 7'd0;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus_if.valid = 1'b0;
    {bus_if.pause, bus_if.resume, bus_if.reset, bus_if.reg_rd,
     bus_if.reg_wr, bus_if.mem_rd, bus_if.mem_wr} = 7'd0;
    bus_if.mem_rw_byte = 1'b0;
    bus_if.addr = 32'd0;
    bus_if.d_in = 32'd0;
    bus_if.cpu_halted = 1'b0;
    bus_if.pc = 32'd0;
    bus_if.mem_rdata = 32'd0;
    bus_if.mem_ack = 1'b0;
    tick(); tick();
    chk("rst_busy", bus_if.mcu_busy, 0);
    chk("rst_cpu_pause", bus_if.cpu_pause, 0);
    chk("rst_d_rd", bus_if.d_rd, 0);
    chk("rst_error", bus_if.error, 0);
    chk("rst_mem_re", bus_if.mem_re, 0);
    chk("rst_cpu_reset", bus_if.cpu_reset, 0);
    rst_n = 1'b1;
    tick();

    // reg_rd while running
    send(C_REG_RD, 0, 32'd7, 0);
    chk("run_rd_busy1", bus_if.mcu_busy, 1);
    chk("run_rd_we1", bus_if.rf_we, 0);
    tick();
    chk("run_rd_busy2", bus_if.mcu_busy, 1);
    tick();
    chk("run_rd_busy3", bus_if.mcu_busy, 0);
    chk("run_rd_error", bus_if.error, 1);
    chk("run_rd_rfaddr", bus_if.rf_addr, 0);
    chk("run_rd_d_rd", bus_if.d_rd, 0);

    // pause with cpu_halted rising at N+6
    send(C_PAUSE, 0, 0, 0);
    chk("pause_cpu_pause", bus_if.cpu_pause, 1);
    chk("pause_busy_n1", bus_if.mcu_busy, 1);
    repeat (5) tick();
    chk("pause_busy_n6", bus_if.mcu_busy, 1);
    bus_if.cpu_halted = 1'b1;
    tick();
    chk("pause_busy_n7", bus_if.mcu_busy, 1);
    tick();
    chk("pause_busy_n8", bus_if.mcu_busy, 0);
    chk("pause_error", bus_if.error, 0);

    // register write then read
    send(C_REG_WR, 0, 32'd7, 32'hDEADBEEF);
    chk("wr_we_n1", bus_if.rf_we, 1);
    chk("wr_addr", bus_if.rf_addr, 7);
    chk("wr_wd", bus_if.rf_wd, 32'hDEADBEEF);
    tick();
    chk("wr_we_n2", bus_if.rf_we, 0);
    tick();
    chk("wr_busy_n3", bus_if.mcu_busy, 0);
    chk("wr_error", bus_if.error, 0);
    send(C_REG_RD, 0, 32'd7, 0);
    tick();
    chk("rd_busy_n2", bus_if.mcu_busy, 1);
    tick();
    chk("rd_busy_n3", bus_if.mcu_busy, 0);
    chk("rd_d_rd", bus_if.d_rd, 32'hDEADBEEF);

    // x0 write is issued without error; out-of-range register rejected
    send(C_REG_WR, 0, 32'd0, 32'h1234);
    chk("x0_we", bus_if.rf_we, 1);
    tick(); tick();
    chk("x0_error", bus_if.error, 0);
    send(C_REG_RD, 0, 32'd40, 0);
    tick(); tick();
    chk("r40_error", bus_if.error, 1);
    chk("r40_d_rd", bus_if.d_rd, 32'hDEADBEEF);

    // byte write, ack in first request cycle
    send(C_MEM_WR, 1, 32'h103, 32'hA5);
    chk("bw_we", bus_if.mem_we, 1);
    chk("bw_addr", bus_if.mem_addr, 32'h100);
    chk("bw_be", bus_if.mem_be, 4'b1000);
    chk("bw_wdata", bus_if.mem_wdata, 32'hA5A5A5A5);
    bus_if.mem_ack = 1'b1;
    tick();
    bus_if.mem_ack = 1'b0;
    chk("bw_we_drop", bus_if.mem_we, 0);
    tick();
    chk("bw_busy_n3", bus_if.mcu_busy, 0);
    chk("bw_error", bus_if.error, 0);

    // byte read with two wait cycles
    bus_if.mem_rdata = 32'h12345678;
    send(C_MEM_RD, 1, 32'h103, 0);
    chk("br_re", bus_if.mem_re, 1);
    tick(); tick();
    bus_if.mem_ack = 1'b1;
    tick();
    bus_if.mem_ack = 1'b0;
    chk("br_re_drop", bus_if.mem_re, 0);
    chk("br_busy_n4", bus_if.mcu_busy, 1);
    tick();
    chk("br_busy_n5", bus_if.mcu_busy, 0);
    chk("br_d_rd", bus_if.d_rd, 32'h12);

    // misaligned word read
    send(C_MEM_RD, 0, 32'h102, 0);
    chk("mis_re", bus_if.mem_re, 0);
    tick(); tick();
    chk("mis_error", bus_if.error, 1);
    chk("mis_d_rd", bus_if.d_rd, 32'h12);

    // timeout: request held exactly 8 cycles
    send(C_MEM_RD, 0, 32'h200, 0);
    repeat (7) tick();
    chk("to_re_n8", bus_if.mem_re, 1);
    tick();
    chk("to_re_n9", bus_if.mem_re, 0);
    tick();
    chk("to_busy", bus_if.mcu_busy, 0);
    chk("to_error", bus_if.error, 1);
    chk("to_d_rd", bus_if.d_rd, 32'h12);

    // ack in the timeout cycle wins
    bus_if.mem_rdata = 32'hCAFEF00D;
    send(C_MEM_RD, 0, 32'h204, 0);
    repeat (7) tick();
    bus_if.mem_ack = 1'b1;
    tick();
    bus_if.mem_ack = 1'b0;
    tick();
    chk("tw_error", bus_if.error, 0);
    chk("tw_d_rd", bus_if.d_rd, 32'hCAFEF00D);

    // pause and resume together
    send(C_PAUSE | C_RESUME, 0, 0, 0);
    tick(); tick();
    chk("pr_error", bus_if.error, 1);
    chk("pr_cpu_pause", bus_if.cpu_pause, 1);

    // CPU reset pulse of 4 cycles, latency 7
    send(C_RESET, 0, 0, 0);
    chk("cr_n1", bus_if.cpu_reset, 1);
    repeat (3) tick();
    chk("cr_n4", bus_if.cpu_reset, 1);
    tick();
    chk("cr_n5", bus_if.cpu_reset, 0);
    tick();
    chk("cr_busy_n6", bus_if.mcu_busy, 1);
    tick();
    chk("cr_busy_n7", bus_if.mcu_busy, 0);
    chk("cr_cpu_pause", bus_if.cpu_pause, 1);
    chk("cr_error", bus_if.error, 0);

    // async reset during held mem_re
    send(C_MEM_RD, 0, 32'h300, 0);
    tick(); tick();
    chk("ar_re_before", bus_if.mem_re, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_re", bus_if.mem_re, 0);
    chk("ar_busy", bus_if.mcu_busy, 0);
    chk("ar_cpu_pause", bus_if.cpu_pause, 0);
    chk("ar_d_rd", bus_if.d_rd, 0);
    tick();
    rst_n = 1'b1;
    tick();
    send(C_RESUME, 0, 0, 0);
    chk("ar_res_busy1", bus_if.mcu_busy, 1);
    tick();
    chk("ar_res_busy2", bus_if.mcu_busy, 1);
    tick();
    chk("ar_res_busy3", bus_if.mcu_busy, 0);
    chk("ar_res_error", bus_if.error, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mcu_db_responder.md
# mcu_db_responder

MCU-side responder for the UART debugger. Accepts one-cycle command strobes from `mcu_controller` (pause, resume, reset, register and memory read/write) and executes them against the CPU's stall/reset controls, register-file debug port and data-memory bus. Returns read data, an error flag and the `mcu_busy` handshake that `mcu_controller` waits on before issuing its next command.

## Interface
- `MEM_TIMEOUT`, default 255: cycles to wait for `mem_ack` before aborting with error.
- `RESET_CYCLES`, default 4: width of the `cpu_reset` pulse, in cycles.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `valid`  in  1  one-cycle command strobe from the controller.
- `pause`, `resume`, `reset`, `reg_rd`, `reg_wr`, `mem_rd`, `mem_wr`  in  1 each  command selects, sampled with `valid`.
- `mem_rw_byte`  in  1  1 selects a byte access, 0 selects a word access.
- `addr`  in  32  register number or byte address.
- `d_in`  in  32  write data.
- `mcu_busy`  out  1  command in progress.
- `d_rd`  out  32  read result.
- `error`  out  1  status of the last command.
- `cpu_pause`  out  1  stall request to the CPU.
- `cpu_halted`  in  1  CPU is stalled and drained.
- `cpu_reset`  out  1  CPU reset pulse.
- `pc`  in  32  current program counter; not consumed by this block.
- `rf_addr`  out  5  register-file debug port address.
- `rf_wd`  out  32  register-file write data.
- `rf_we`  out  1  register-file write enable.
- `rf_rd`  in  32  register-file read data; combinational read.
- `mem_addr`  out  32  word-aligned memory address.
- `mem_wdata`  out  32  memory write data.
- `mem_be`  out  4  memory byte enables.
- `mem_re`, `mem_we`  out  1 each  memory read and write requests.
- `mem_rdata`  in  32  memory read data.
- `mem_ack`  in  1  memory access complete.

## Operation
- **States:** IDLE, PAUSE_WAIT, RST, REG, MEM, DONE.
- **Reset values:** all outputs 0; state IDLE; internal paused flag 0.
- **Command capture:** in IDLE, `valid` high latches all command inputs and moves to the command's state. `valid` outside IDLE is ignored.
- **Command validation:** exactly one command select must be set.
  - Zero or more than one set: go to DONE with `error`=1; no side effects.
- **pause:**
  - `cpu_pause`=1 and paused=1; go to PAUSE_WAIT.
  - PAUSE_WAIT leaves to DONE once `cpu_halted` is sampled high.
  - Pausing while already paused is legal.
- **resume:** `cpu_pause`=0 and paused=0; go to DONE.
- **reset:**
  - RST drives `cpu_reset`=1 for `RESET_CYCLES` cycles, then goes to DONE.
  - The paused flag and `cpu_pause` are unchanged.
- **reg_rd / reg_wr:**
  - Not paused: error. Any address ≥ 32: error.
  - Otherwise REG lasts one cycle with `rf_addr`=`addr[4:0]`.
  - Read: `d_rd` latches `rf_rd`.
  - Write: `rf_we`=1 and `rf_wd`=`d_in`. A write to x0 is issued normally; the register file discards it. No error is raised.
- **mem_rd / mem_wr:**
  - Not paused: error. Word access with `addr[1:0]`≠0: error.
  - `mem_addr`={`addr[31:2]`,2'b00}.
  - Byte access: `mem_be`=1<<`addr[1:0]` and `mem_wdata`={4{`d_in[7:0]`}}.
  - Word access: `mem_be`=4'hF and `mem_wdata`=`d_in`.
  - `mem_re` or `mem_we` is held until `mem_ack` is sampled high.
  - Read data: byte read returns the selected lane of `mem_rdata`, zero-extended; word read returns `mem_rdata`.
  - If `MEM_TIMEOUT` cycles pass without `mem_ack`: drop the request and set `error`=1; `d_rd` is unchanged.
- **Result hold:** `error` and `d_rd` are written only in DONE-bound transitions and hold until the next accepted command. `error` is cleared to 0 on every successful command.
- **Busy:** `mcu_busy`=1 in every state except IDLE.

## Timing
- `valid` is sampled at edge N; `mcu_busy` rises in cycle N+1.
- DONE lasts exactly 1 cycle; `mcu_busy` is 0 in the cycle after DONE. `d_rd`/`error` are valid when `mcu_busy` falls.
- Latency from `valid` to `mcu_busy` low:
  - reg_rd/reg_wr/resume/error: 3 cycles.
  - reset: RESET_CYCLES+3.
  - mem: 3 + wait cycles.
  - pause: 3 + halt wait.
- `cpu_pause` changes at N+1 for pause and resume.
- `rf_we` is high for exactly 1 cycle.
- `mem_re`/`mem_we` fall in the cycle after `mem_ack`.
- `mem_ack` in the first request cycle completes with zero wait cycles.
- Timeout counter: counts request cycles; an ack arriving in the same cycle as the timeout wins and completes without error.
- `rst_n` low mid-command aborts immediately to the reset values; no completion and no DONE.

## Test plan
- **Pause handshake:** pause command; `cpu_halted` rises 5 cycles later. Required: `cpu_pause`=1 from N+1, `mcu_busy` falls at N+8, `error`=0.
- **Register write then read:** paused; reg_wr `addr`=7, `d_in`=0xDEADBEEF; then reg_rd `addr`=7. Required: one-cycle `rf_we` with `rf_addr`=7, then `d_rd`=0xDEADBEEF and `mcu_busy` low 3 cycles after each `valid`.
- **Byte accesses:** paused; mem_wr byte `addr`=0x103, `d_in`=0xA5. Required: `mem_addr`=0x100, `mem_be`=4'b1000, `mem_wdata`=0xA5A5A5A5. Then mem_rd byte at the same address with `mem_rdata`=0x12345678 returns `d_rd`=0x12.
- **Command errors:**
  - reg_rd while running: `error`=1, no `rf` activity.
  - Word mem_rd at `addr`=0x102: `error`=1, no `mem_re`.
  - `valid` with pause and resume both set: `error`=1, `cpu_pause` unchanged.
- **Memory timeout:** paused; mem_rd with `mem_ack` never asserted and `MEM_TIMEOUT`=8. Required: `mem_re` drops after 8 cycles, `error`=1, `d_rd` holds its prior value.
- **Async reset mid-access:** `rst_n` pulled low during a held `mem_re`. Required: `mem_re`, `mcu_busy`, `cpu_pause` and `d_rd` all 0 asynchronously; after release, the block accepts a resume with normal latency.
